// File: rtl/vga_pixel_fetch.sv
// Raster-order pixel fetcher feeding the VGA output stage.
// It reads 8-bit pixels from a synchronous image memory (1-cycle latency) and
// buffers them in a show-ahead FIFO. Pixels leave through a valid/ready stream
// tagged with start-of-frame and end-of-line. Reads are issued only when a
// FIFO slot is guaranteed, so backpressure never drops or duplicates a pixel.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start               begins a frame when idle (ignored otherwise)
//   mem_rd, mem_addr    image memory read strobe and address
//   mem_data            read data, valid one cycle after mem_rd
//   pix_data/valid/ready/sof/eol  pixel stream to the VGA stage
//   busy                frame in progress
//   done                one-cycle pulse once the last pixel is delivered
module vga_pixel_fetch #(
  parameter int unsigned H_ACTIVE   = 640,
  parameter int unsigned V_ACTIVE   = 480,
  parameter int unsigned ADDR_W     = 19,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_data,
  output logic [7:0]        pix_data,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic              pix_sof,
  output logic              pix_eol,
  output logic              busy,
  output logic              done
);

  localparam int unsigned XW    = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
  localparam int unsigned YW    = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
  localparam int unsigned PW    = $clog2(FIFO_DEPTH);
  localparam int unsigned CW    = PW + 1;
  localparam int unsigned OW    = CW + 1;
  localparam int unsigned ENT_W = 10;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(H_ACTIVE * V_ACTIVE - 1);
  localparam logic [XW-1:0]     X_LAST    = XW'(H_ACTIVE - 1);
  localparam logic [YW-1:0]     Y_LAST    = YW'(V_ACTIVE - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic              rd_q;
  logic              rd_d;
  logic [ADDR_W-1:0] addr_q;
  logic [XW-1:0]     x_q;
  logic [YW-1:0]     y_q;

  // Read in flight plus the tags that travel with it
  logic              inflight_q;
  logic              sof_q;
  logic              eol_q;

  logic [ENT_W-1:0]  fifo_q [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr_q;
  logic [PW-1:0]     rd_ptr_q;
  logic [CW-1:0]     count_q;

  logic              push_c;
  logic              pop_c;
  logic [CW-1:0]     count_d;
  logic [OW-1:0]     credit_c;
  logic              last_issue_c;
  logic [ENT_W-1:0]  head_c;

  assign mem_rd    = rd_q;
  assign mem_addr  = addr_q;
  assign head_c    = fifo_q[rd_ptr_q];
  assign pix_data  = head_c[7:0];
  assign pix_eol   = head_c[8];
  assign pix_sof   = head_c[9];
  assign pix_valid = (count_q != '0);

  // Next state and next read strobe; the read decision looks at next-cycle
  // occupancy plus the read issued this cycle so a slot is always reserved.
  always_comb begin
    push_c       = inflight_q;
    pop_c        = (count_q != '0) && pix_ready;
    count_d      = count_q + CW'(push_c) - CW'(pop_c);
    last_issue_c = rd_q && (addr_q == LAST_ADDR);
    state_d      = state_q;
    credit_c     = '0;
    rd_d         = 1'b0;

    case (state_q)
      ST_IDLE:  if (start)        state_d = ST_FETCH;
      ST_FETCH: if (last_issue_c) state_d = ST_DRAIN;
      ST_DRAIN: if ((count_d == '0) && !rd_q) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    credit_c = OW'(count_d) + OW'(rd_q);
    rd_d     = (state_d == ST_FETCH) && (credit_c < OW'(FIFO_DEPTH));
  end

  // FSM state and registered control outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      rd_q    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      rd_q    <= rd_d;
      busy    <= (state_d != ST_IDLE);
      done    <= (state_d == ST_DONE);
    end
  end

  // Raster counters advance once per issued read; tags are captured at issue
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q     <= '0;
      x_q        <= '0;
      y_q        <= '0;
      inflight_q <= 1'b0;
      sof_q      <= 1'b0;
      eol_q      <= 1'b0;
    end else begin
      inflight_q <= rd_q;
      if (rd_q) begin
        sof_q <= (x_q == '0) && (y_q == '0);
        eol_q <= (x_q == X_LAST);
      end
      if (state_q == ST_IDLE) begin
        addr_q <= '0;
        x_q    <= '0;
        y_q    <= '0;
      end else if (rd_q) begin
        addr_q <= addr_q + ADDR_W'(1);
        if (x_q == X_LAST) begin
          x_q <= '0;
          y_q <= (y_q == Y_LAST) ? '0 : y_q + YW'(1);
        end else begin
          x_q <= x_q + XW'(1);
        end
      end
    end
  end

  // Show-ahead FIFO; storage is reset so the stream outputs read 0 after reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) fifo_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_c) begin
        fifo_q[wr_ptr_q] <= {sof_q, eol_q, mem_data};
        wr_ptr_q         <= wr_ptr_q + PW'(1);
      end
      if (pop_c) rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q <= count_d;
    end
  end

endmodule
